// File: rtl/alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer
//
// Issue stage in front of a WIDTH-bit bit-serial ALU. One operation is accepted
// per req_valid/req_ready handshake. The ALU bit-state is cleared with opcode
// 000 for one cycle, the operands and opcode are then held for WIDTH serial RUN
// cycles, and after one more clearing cycle the ALU result and flags are
// captured and returned on the rsp_valid/rsp_ready channel. Illegal opcodes
// never reach the ALU: they are answered in the cycle after acceptance with
// rsp_err=1 and an all-zero result.
//
// Ports
//   clk                      clock, all logic on the rising edge
//   reset                    synchronous, active-low reset
//   req_valid / req_ready    request handshake (req_ready is registered)
//   req_a, req_b             operands (WIDTH bits)
//   req_op                   001 NOR, 010 ADD, 011 XNOR, 100 SUB, others illegal
//   alu_srcA, alu_srcB       operands driven to the ALU
//   alu_opCode               opcode driven to the ALU (000 clears its bit-state)
//   alu_result               ALU result (WIDTH bits)
//   alu_zero/carry/sign      ALU flags (carry is borrow for SUB)
//   rsp_valid / rsp_ready    response handshake
//   rsp_result               captured ALU result
//   rsp_zero/carry/sign      captured ALU flags
//   rsp_err                  1 = illegal opcode, result and flags forced to 0
// -----------------------------------------------------------------------------
module alu_op_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  // request channel
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [2:0]       req_op,
  // ALU interface
  output logic [WIDTH-1:0] alu_srcA,
  output logic [WIDTH-1:0] alu_srcB,
  output logic [2:0]       alu_opCode,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  input  logic             alu_carry,
  input  logic             alu_sign,
  // response channel
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_carry,
  output logic             rsp_sign,
  output logic             rsp_err
);

  // ---------------------------------------------------------------------------
  // Constants
  // ---------------------------------------------------------------------------
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] CLEAR   = 3'd1;
  localparam logic [2:0] RUN     = 3'd2;
  localparam logic [2:0] CAPTURE = 3'd3;
  localparam logic [2:0] HOLD    = 3'd4;

  localparam logic [2:0] OP_CLR  = 3'b000;
  localparam logic [2:0] OP_NOR  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_XNOR = 3'b011;
  localparam logic [2:0] OP_SUB  = 3'b100;

  // Counter value seen during the last of the WIDTH RUN cycles.
  localparam logic [WIDTH-1:0] RUN_LAST = WIDTH'(WIDTH - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [2:0]       state_q,      state_d;
  logic [2:0]       op_q,         op_d;
  logic [WIDTH-1:0] src_a_q,      src_a_d;
  logic [WIDTH-1:0] src_b_q,      src_b_d;
  logic [WIDTH-1:0] cnt_q,        cnt_d;
  logic             req_ready_q,  req_ready_d;
  logic [2:0]       alu_op_q,     alu_op_d;
  logic             rsp_valid_q,  rsp_valid_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_zero_q,   rsp_zero_d;
  logic             rsp_carry_q,  rsp_carry_d;
  logic             rsp_sign_q,   rsp_sign_d;
  logic             rsp_err_q,    rsp_err_d;

  logic             accept;
  logic             op_legal;

  assign accept   = (state_q == IDLE) && req_valid && req_ready_q;
  assign op_legal = (req_op == OP_NOR) || (req_op == OP_ADD) ||
                    (req_op == OP_XNOR) || (req_op == OP_SUB);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every variable gets a hold default before the case statement so no
  // path through this block leaves a value unassigned (which would infer a latch).
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    src_a_d      = src_a_q;
    src_b_d      = src_b_q;
    cnt_d        = cnt_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_carry_d  = rsp_carry_q;
    rsp_sign_d   = rsp_sign_q;
    rsp_err_d    = rsp_err_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d    = req_op;
          src_a_d = req_a;
          src_b_d = req_b;
          if (op_legal) begin
            state_d = CLEAR;
          end else begin
            // Illegal opcodes bypass the ALU entirely and answer immediately.
            state_d      = HOLD;
            rsp_valid_d  = 1'b1;
            rsp_err_d    = 1'b1;
            rsp_result_d = '0;
            rsp_zero_d   = 1'b0;
            rsp_carry_d  = 1'b0;
            rsp_sign_d   = 1'b0;
          end
        end
      end

      CLEAR: begin
        cnt_d   = '0;
        state_d = RUN;
      end

      RUN: begin
        if (cnt_q == RUN_LAST) begin
          state_d = CAPTURE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      CAPTURE: begin
        // Flags are passed through untouched; the ALU owns their meaning.
        rsp_valid_d  = 1'b1;
        rsp_err_d    = 1'b0;
        rsp_result_d = alu_result;
        rsp_zero_d   = alu_zero;
        rsp_carry_d  = alu_carry;
        rsp_sign_d   = alu_sign;
        state_d      = HOLD;
      end

      HOLD: begin
        // Returning to IDLE takes a full edge; the next accept is one cycle later.
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Registered outputs are derived from the state being entered so that they
    // line up with that state for its whole duration.
    req_ready_d = (state_d == IDLE);
    alu_op_d    = (state_d == RUN) ? op_d : OP_CLR;
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: reset is sampled only on the clock edge, and every register
  // (operands included) is cleared so outputs are deterministic out of reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      op_q         <= OP_CLR;
      src_a_q      <= '0;
      src_b_q      <= '0;
      cnt_q        <= '0;
      req_ready_q  <= 1'b0;
      alu_op_q     <= OP_CLR;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_carry_q  <= 1'b0;
      rsp_sign_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      src_a_q      <= src_a_d;
      src_b_q      <= src_b_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= req_ready_d;
      alu_op_q     <= alu_op_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_carry_q  <= rsp_carry_d;
      rsp_sign_q   <= rsp_sign_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign req_ready  = req_ready_q;
  assign alu_srcA   = src_a_q;
  assign alu_srcB   = src_b_q;
  assign alu_opCode = alu_op_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;
  assign rsp_carry  = rsp_carry_q;
  assign rsp_sign   = rsp_sign_q;
  assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_op_sequencer
//
// Drives alu_op_sequencer with a table of directed operations whose results
// were worked out by hand, plus hand-written sequences for back-to-back
// throughput, response backpressure and reset in the middle of RUN. A small
// behavioural ALU stands in for the bit-serial ALU.
// -----------------------------------------------------------------------------
module tb_alu_op_sequencer;

  localparam int WIDTH = 4;

  logic             clk;
  logic             reset;
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [2:0]       req_op;
  logic [WIDTH-1:0] alu_srcA;
  logic [WIDTH-1:0] alu_srcB;
  logic [2:0]       alu_opCode;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;
  logic             alu_carry;
  logic             alu_sign;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_zero;
  logic             rsp_carry;
  logic             rsp_sign;
  logic             rsp_err;

  int n_checks = 0;
  int n_fail   = 0;

  alu_op_sequencer #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .alu_srcA   (alu_srcA),
    .alu_srcB   (alu_srcB),
    .alu_opCode (alu_opCode),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .alu_carry  (alu_carry),
    .alu_sign   (alu_sign),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .rsp_carry  (rsp_carry),
    .rsp_sign   (rsp_sign),
    .rsp_err    (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: updates its result on every edge with a nonzero opcode
  // and holds it while the opcode is 000.
  logic [WIDTH-1:0] stub_res = '0;
  logic             stub_c   = 1'b0;
  logic [WIDTH:0]   stub_sum;

  always_comb stub_sum = {1'b0, alu_srcA} + {1'b0, alu_srcB};

  always @(posedge clk) begin
    case (alu_opCode)
      3'b001: begin stub_res <= ~(alu_srcA | alu_srcB); stub_c <= 1'b0;                end
      3'b010: begin stub_res <= stub_sum[WIDTH-1:0];    stub_c <= stub_sum[WIDTH];     end
      3'b011: begin stub_res <= ~(alu_srcA ^ alu_srcB); stub_c <= 1'b0;                end
      3'b100: begin stub_res <= alu_srcA - alu_srcB;    stub_c <= (alu_srcA < alu_srcB); end
      default: ;
    endcase
  end

  assign alu_result = stub_res;
  assign alu_carry  = stub_c;
  assign alu_zero   = (stub_res == '0);
  assign alu_sign   = stub_res[WIDTH-1];

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  typedef struct {
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] res;
    logic             z;
    logic             c;
    logic             s;
    logic             err;
  } vec_t;

  localparam int NVEC = 11;
  vec_t vecs [NVEC];

  // Runs one operation from an IDLE cycle (called at a falling edge) through
  // to response consumption, checking latency, ALU drive and response fields.
  task automatic do_op(input vec_t v, input string tag);
    int lat;
    int nz;
    int wrong;
    bit legal;
    legal = (v.op == 3'b001) || (v.op == 3'b010) || (v.op == 3'b011) || (v.op == 3'b100);
    check({tag, " req_ready idle"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_a     = v.a;
    req_b     = v.b;
    req_op    = v.op;
    @(posedge clk);            // accept edge, cycle 0
    @(negedge clk);            // cycle 1
    req_valid = 1'b0;
    lat   = 1;
    nz    = 0;
    wrong = 0;
    while (!rsp_valid && lat < 30) begin
      if (alu_opCode != 3'b000) begin
        nz++;
        if (alu_opCode != v.op || alu_srcA != v.a || alu_srcB != v.b) wrong++;
      end
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"},     32'(lat),   legal ? 32'(WIDTH + 3) : 32'd1);
    check({tag, " run cycles"},  32'(nz),    legal ? 32'(WIDTH) : 32'd0);
    check({tag, " alu drive"},   32'(wrong), 32'd0);
    check({tag, " rsp_result"},  32'(rsp_result), 32'(v.res));
    check({tag, " rsp_flags"},   {28'd0, rsp_zero, rsp_carry, rsp_sign, rsp_err},
                                 {28'd0, v.z, v.c, v.s, v.err});
    check({tag, " req_ready hold"}, 32'(req_ready), 32'd0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, " rsp_valid drop"}, 32'(rsp_valid), 32'd0);
    check({tag, " req_ready back"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    int hits;
    int first_hit;
    int second_hit;
    int bad;
    int lat;
    logic [7:0] snap;

    //            op      a        b        res      z     c     s     err
    vecs[0]  = '{3'b010, 4'b0111, 4'b1001, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{3'b100, 4'b0011, 4'b0101, 4'b1110, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{3'b001, 4'b0000, 4'b0000, 4'b1111, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{3'b110, 4'b0101, 4'b0011, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{3'b011, 4'b1010, 4'b1010, 4'b1111, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{3'b000, 4'b1111, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{3'b100, 4'b0101, 4'b0011, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{3'b111, 4'b0010, 4'b0010, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{3'b010, 4'b1000, 4'b1000, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{3'b101, 4'b1001, 4'b0110, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{3'b001, 4'b1100, 4'b0011, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0};

    reset     = 1'b0;
    req_valid = 1'b0;
    req_a     = '0;
    req_b     = '0;
    req_op    = 3'b000;
    rsp_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset req_ready",  32'(req_ready),  32'd0);
    check("reset alu_opCode", 32'(alu_opCode), 32'd0);
    check("reset rsp_valid",  32'(rsp_valid),  32'd0);
    check("reset outputs",    {16'd0, alu_srcA, alu_srcB, rsp_result, rsp_zero, rsp_carry, rsp_sign, rsp_err},
                              32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("release req_ready", 32'(req_ready), 32'd1);

    // Directed table
    for (int i = 0; i < NVEC; i++) begin
      do_op(vecs[i], $sformatf("vec%0d", i));
    end

    // Back-to-back throughput: ADD 0010+0011 = 0101, rsp_ready held high
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_a     = 4'b0010;
    req_b     = 4'b0011;
    req_op    = 3'b010;
    hits = 0; first_hit = 0; second_hit = 0; bad = 0;
    @(posedge clk);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        hits++;
        if (hits == 1) first_hit = k;
        if (hits == 2) begin second_hit = k; req_valid = 1'b0; end
        if (rsp_result != 4'b0101 || rsp_err) bad++;
      end
    end
    rsp_ready = 1'b0;
    check("b2b first rsp",  32'(first_hit),  32'(WIDTH + 3));
    check("b2b second rsp", 32'(second_hit), 32'(2 * WIDTH + 7));
    check("b2b rsp count",  32'(hits),       32'd2);
    check("b2b rsp data",   32'(bad),        32'd0);
    check("b2b idle",       32'(req_ready),  32'd1);

    // Backpressure: SUB 0111-0010 = 0101, consumer stalls 10 cycles
    req_valid = 1'b1;
    req_a     = 4'b0111;
    req_b     = 4'b0010;
    req_op    = 3'b100;
    @(posedge clk);
    @(negedge clk);
    req_a  = 4'b0001;          // second request waits behind the stalled response
    req_b  = 4'b0001;
    req_op = 3'b010;
    lat = 1;
    while (!rsp_valid && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    check("bp latency", 32'(lat), 32'(WIDTH + 3));
    snap = {rsp_result, rsp_zero, rsp_carry, rsp_sign, rsp_err};
    check("bp rsp", 32'(snap), 32'({4'b0101, 1'b0, 1'b0, 1'b0, 1'b0}));
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (!rsp_valid || req_ready || alu_opCode != 3'b000 ||
          {rsp_result, rsp_zero, rsp_carry, rsp_sign, rsp_err} != snap) bad++;
    end
    check("bp stall stable", 32'(bad), 32'd0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("bp release rsp_valid", 32'(rsp_valid), 32'd0);
    check("bp release req_ready", 32'(req_ready), 32'd1);
    @(posedge clk);            // second request accepted here
    @(negedge clk);
    req_valid = 1'b0;
    check("bp second accepted", 32'(req_ready), 32'd0);
    lat = 1;
    while (!rsp_valid && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    check("bp second latency", 32'(lat), 32'(WIDTH + 3));
    check("bp second result", {27'd0, rsp_result, rsp_err}, {27'd0, 4'b0010, 1'b0});
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;

    // Reset asserted during the second RUN cycle
    req_valid = 1'b1;
    req_a     = 4'b0110;
    req_b     = 4'b0011;
    req_op    = 3'b010;
    @(posedge clk);            // accept, cycle 0
    @(negedge clk);            // cycle 1: CLEAR
    req_valid = 1'b0;
    @(negedge clk);            // cycle 2: RUN 1
    @(negedge clk);            // cycle 3: RUN 2
    check("mid-run opcode", 32'(alu_opCode), 32'(3'b010));
    reset = 1'b0;
    @(negedge clk);
    check("mid-run reset opcode",    32'(alu_opCode), 32'd0);
    check("mid-run reset rsp_valid", 32'(rsp_valid),  32'd0);
    check("mid-run reset req_ready", 32'(req_ready),  32'd0);
    reset = 1'b1;
    hits = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (rsp_valid) hits++;
    end
    check("abandoned op no rsp", 32'(hits), 32'd0);
    do_op('{3'b010, 4'b0001, 4'b0001, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0}, "post-reset add");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
